operand_requester: RTL and testbench

- Per-lane operand fetch engine. It is the consumer end of the op_req_t request path.
- It accepts one op_req_t at a time from the sequencer and turns it into a stream of VRF word reads on a single shared VRF read port.
- It steers the returned words into the operand queues (ALUA, ALUB, StoreOp) that feed the lane VFUs.
- Per-queue credit accounting guarantees returned read data is never dropped.

---
 rtl/core_pkg.sv | 66 ++++++
 rtl/operand_requester_fifo.sv | 77 +++++++
 rtl/operand_requester.sv | 199 +++++++++++++++++++
 tb/tb_operand_requester.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared lane types and helpers for the operand fetch path.
// Holds the request/queue types plus the word-count, address and
// operand-source helper functions used by operand_requester.
package core_pkg;

  localparam int unsigned NrLane           = 2;
  localparam int unsigned ElenB            = 8;
  localparam int unsigned VlenBits         = 1024;
  localparam int unsigned NrVReg           = 32;
  localparam int unsigned ByteBlock        = NrLane * ElenB;
  localparam int unsigned ByteBlockWidth   = $clog2(ByteBlock);
  localparam int unsigned RegSliceNumWords = (VlenBits / 8) / ByteBlock;
  localparam int unsigned SliceWordBits    = $clog2(RegSliceNumWords);
  localparam int unsigned VRegWidth        = $clog2(NrVReg);
  localparam int unsigned VrfAddrWidth     = VRegWidth + SliceWordBits;
  localparam int unsigned VlenWidth        = 16;
  localparam int unsigned WordCntWidth     = $clog2(RegSliceNumWords + 1);
  localparam int unsigned NrOpQueue        = 3;
  localparam int unsigned OpQueueDepth     = 4;

  typedef logic [VRegWidth-1:0]    vreg_t;
  typedef logic [VlenWidth-1:0]    vlen_t;
  typedef logic [VlenWidth:0]      vlen_ext_t;
  typedef logic [VrfAddrWidth-1:0] vrf_addr_t;
  typedef logic [ElenB*8-1:0]      vrf_data_t;
  typedef logic [WordCntWidth-1:0] word_cnt_t;

  typedef enum logic [1:0] {
    ALUA    = 2'd0,
    ALUB    = 2'd1,
    StoreOp = 2'd2
  } op_queue_e;

  typedef struct packed {
    vreg_t                 vs1;
    vreg_t                 vs2;
    logic [NrOpQueue-1:0]  queue_req;
    vlen_t                 vlB;
  } op_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } req_state_e;

  // ALUB consumes vs2; ALUA and the store path both consume vs1.
  function automatic vreg_t GetOpSrcVReg(op_queue_e q, vreg_t vs1, vreg_t vs2);
    return (q == ALUB) ? vs2 : vs1;
  endfunction

  // Number of words this lane holds for vlB bytes, capped at one register slice.
  function automatic word_cnt_t GetLaneWords(vlen_t vlB);
    vlen_ext_t rounded;
    rounded = ({1'b0, vlB} + vlen_ext_t'(ByteBlock - 1)) >> ByteBlockWidth;
    if (rounded > vlen_ext_t'(RegSliceNumWords)) begin
      return word_cnt_t'(RegSliceNumWords);
    end
    return word_cnt_t'(rounded);
  endfunction

  // First word of a vector register's slice in this lane's VRF.
  function automatic vrf_addr_t GetVRFAddr(vreg_t v);
    return vrf_addr_t'(v) << SliceWordBits;
  endfunction

endpackage

// File: rtl/operand_requester_fifo.sv
// op_queue_fifo: small circular FIFO holding fetched operand words.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module op_queue_fifo #(
  parameter int unsigned Depth  = 4,
  parameter type         data_t = logic [63:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  data_t                      data_i,
  input  logic                       pop_i,
  output data_t                      data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] occupancy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned OccW = $clog2(Depth + 1);

  data_t           mem_q [Depth];
  data_t           mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] NextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o     = (occ_q == '0);
  assign full_o      = (occ_q == OccW'(Depth));
  assign occupancy_o = occ_q;
  assign data_o      = mem_q[rd_ptr_q];
  assign do_pop      = pop_i && !empty_o;
  assign do_push     = push_i && (!full_o || do_pop);

  // Advance pointers, write storage and track occupancy for this cycle's push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = NextPtr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = NextPtr(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (do_pop && !do_push) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // Pointer and occupancy state; reset empties the queue at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/operand_requester.sv
// operand_requester: turns one op_req_t into a stream of VRF word reads and
// steers returned words into the ALUA / ALUB / StoreOp operand queues.
// Credit (occupancy + in-flight < depth) keeps return data from overflowing.
// Optional macro OPERAND_REQUESTER_STALL_CNT_EN adds a 32-bit saturating
// stall_cnt_o counting BUSY cycles without a VRF handshake.
module operand_requester
  import core_pkg::*;
#(
  parameter int unsigned QueueDepth = OpQueueDepth,
  parameter int unsigned NumQueue   = NrOpQueue
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  op_req_t             op_req_i,
  input  logic                op_req_valid_i,
  output logic                op_req_ready_o,
  output logic                vrf_req_valid_o,
  output vrf_addr_t           vrf_raddr_o,
  input  logic                vrf_req_ready_i,
  input  vrf_data_t           vrf_rdata_i,
  output vrf_data_t           opq_data_o [NumQueue],
  output logic [NumQueue-1:0] opq_valid_o,
  input  logic [NumQueue-1:0] opq_ready_i
`ifdef OPERAND_REQUESTER_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  localparam int unsigned QIdxW = (NumQueue > 1) ? $clog2(NumQueue) : 1;
  localparam int unsigned OccW  = $clog2(QueueDepth + 1);

  req_state_e       state_q, state_d;
  vreg_t            vs1_q, vs1_d;
  vreg_t            vs2_q, vs2_d;
  word_cnt_t        remaining_q [NumQueue];
  word_cnt_t        remaining_d [NumQueue];
  word_cnt_t        k_q [NumQueue];
  word_cnt_t        k_d [NumQueue];
  logic             inflight_valid_q, inflight_valid_d;
  logic [QIdxW-1:0] inflight_tag_q, inflight_tag_d;
  logic [QIdxW-1:0] rr_q, rr_d;

  logic [NumQueue-1:0] push;
  logic [NumQueue-1:0] full;
  logic [NumQueue-1:0] empty;
  logic [OccW-1:0]     occupancy [NumQueue];
  logic [NumQueue-1:0] eligible;
  logic                grant_valid;
  logic [QIdxW-1:0]    grant_idx;
  int unsigned         cand;
  vreg_t               src_vreg;
  word_cnt_t           req_words;
  logic                vrf_hs;
  logic                any_left;

  assign op_req_ready_o  = (state_q == IDLE);
  assign vrf_req_valid_o = grant_valid;
  assign vrf_hs          = vrf_req_valid_o && vrf_req_ready_i;
  assign req_words       = GetLaneWords(op_req_i.vlB);
  assign src_vreg        = GetOpSrcVReg(op_queue_e'(grant_idx), vs1_q, vs2_q);
  assign vrf_raddr_o     = grant_valid ? (GetVRFAddr(src_vreg) + vrf_addr_t'(k_q[grant_idx])) : '0;

  // Return-data steering and per-queue issue eligibility under credit.
  always_comb begin
    push     = '0;
    eligible = '0;
    for (int q = 0; q < NumQueue; q++) begin
      push[q]     = inflight_valid_q && (int'(inflight_tag_q) == q);
      eligible[q] = (state_q == BUSY) && (remaining_q[q] != '0) && !full[q] &&
                    ((int'(occupancy[q]) + int'(push[q])) < int'(QueueDepth));
    end
  end

  // Round-robin pick among eligible queues, starting at the priority pointer.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NumQueue; i++) begin
      cand = (int'(rr_q) + i) % NumQueue;
      if (!grant_valid && eligible[QIdxW'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = QIdxW'(cand);
      end
    end
  end

  // Request acceptance, per-queue word bookkeeping and IDLE/BUSY sequencing.
  always_comb begin
    state_d          = state_q;
    vs1_d            = vs1_q;
    vs2_d            = vs2_q;
    remaining_d      = remaining_q;
    k_d              = k_q;
    inflight_valid_d = 1'b0;
    inflight_tag_d   = inflight_tag_q;
    rr_d             = rr_q;
    any_left         = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_req_valid_i) begin
          vs1_d = op_req_i.vs1;
          vs2_d = op_req_i.vs2;
          for (int q = 0; q < NumQueue; q++) begin
            remaining_d[q] = op_req_i.queue_req[q] ? req_words : '0;
            k_d[q]         = '0;
          end
          if ((req_words != '0) && (op_req_i.queue_req != '0)) begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (vrf_hs) begin
          remaining_d[grant_idx] = remaining_q[grant_idx] - word_cnt_t'(1);
          k_d[grant_idx]         = k_q[grant_idx] + word_cnt_t'(1);
          inflight_valid_d       = 1'b1;
          inflight_tag_d         = grant_idx;
          rr_d = (int'(grant_idx) == NumQueue - 1) ? '0 : grant_idx + QIdxW'(1);
          for (int q = 0; q < NumQueue; q++) begin
            if (remaining_d[q] != '0) begin
              any_left = 1'b1;
            end
          end
          if (!any_left) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Requester state; reset drops any pending request and in-flight word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      vs1_q            <= '0;
      vs2_q            <= '0;
      remaining_q      <= '{default: '0};
      k_q              <= '{default: '0};
      inflight_valid_q <= 1'b0;
      inflight_tag_q   <= '0;
      rr_q             <= '0;
    end else begin
      state_q          <= state_d;
      vs1_q            <= vs1_d;
      vs2_q            <= vs2_d;
      remaining_q      <= remaining_d;
      k_q              <= k_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_tag_q   <= inflight_tag_d;
      rr_q             <= rr_d;
    end
  end

  for (genvar g = 0; g < NumQueue; g++) begin : gen_opq
    op_queue_fifo #(
      .Depth  (QueueDepth),
      .data_t (vrf_data_t)
    ) i_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push[g]),
      .data_i      (vrf_rdata_i),
      .pop_i       (opq_valid_o[g] && opq_ready_i[g]),
      .data_o      (opq_data_o[g]),
      .full_o      (full[g]),
      .empty_o     (empty[g]),
      .occupancy_o (occupancy[g])
    );
    assign opq_valid_o[g] = !empty[g];
  end

`ifdef OPERAND_REQUESTER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count BUSY cycles that end without a VRF handshake, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == BUSY) && !vrf_hs && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_requester.sv
// Directed testbench for operand_requester: per-cycle vector table for the
// single-queue, round-robin and zero-length cases, plus hand-written
// sequences for credit backpressure, port stalls and reset mid-request.
module tb_operand_requester;
  import core_pkg::*;

  logic        clk_i;
  logic        rst_i;
  op_req_t     op_req;
  logic        op_req_valid;
  logic        op_req_ready;
  logic        vrf_req_valid;
  vrf_addr_t   vrf_raddr;
  logic        vrf_req_ready;
  vrf_data_t   vrf_rdata;
  vrf_data_t   opq_data [3];
  logic [2:0]  opq_valid;
  logic [2:0]  opq_ready;
`ifdef OPERAND_REQUESTER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks    = 0;
  int failures  = 0;
  int hs_count  = 0;
  int hs_base   = 0;
  bit track_busy = 0;
  int track_hs   = 0;
  int track_target = 0;
  int exp_stall  = 0;

  typedef struct {
    logic       rst;
    logic       req_valid;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [2:0] qreq;
    logic [15:0] vlb;
    logic       vrf_ready;
    logic [2:0] opq_rdy;
    logic       exp_op_ready;
    logic       exp_vrf_valid;
    logic [7:0] exp_addr;
    logic [2:0] exp_opq_valid;
  } vec_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];

  operand_requester dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .op_req_i        (op_req),
    .op_req_valid_i  (op_req_valid),
    .op_req_ready_o  (op_req_ready),
    .vrf_req_valid_o (vrf_req_valid),
    .vrf_raddr_o     (vrf_raddr),
    .vrf_req_ready_i (vrf_req_ready),
    .vrf_rdata_i     (vrf_rdata),
    .opq_data_o      (opq_data),
    .opq_valid_o     (opq_valid),
    .opq_ready_i     (opq_ready)
`ifdef OPERAND_REQUESTER_STALL_CNT_EN
    ,
    .stall_cnt_o     (stall_cnt)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic vrf_data_t mkData(vrf_addr_t a);
    return {32'hC0DE_5EED, 24'h0, a};
  endfunction

  // VRF model: answers each granted read with address-tagged data one cycle later.
  always @(posedge clk_i) begin
    vrf_rdata <= (vrf_req_valid && vrf_req_ready) ? mkData(vrf_raddr) : 64'h0BAD_0BAD_0BAD_0BAD;
  end

  // Handshake counter and expected stall count while a tracked request is busy.
  always @(posedge clk_i) begin
    if (!rst_i && vrf_req_valid && vrf_req_ready) hs_count++;
    if (track_busy) begin
      if (vrf_req_valid && vrf_req_ready) begin
        track_hs++;
        if (track_hs == track_target) track_busy = 0;
      end else begin
        exp_stall++;
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk_i);
    rst_i            = v.rst;
    op_req_valid     = v.req_valid;
    op_req.vs1       = v.vs1;
    op_req.vs2       = v.vs2;
    op_req.queue_req = v.qreq;
    op_req.vlB       = v.vlb;
    vrf_req_ready    = v.vrf_ready;
    opq_ready        = v.opq_rdy;
    #1;
    checkOutput({tag, " op_ready"}, 64'(op_req_ready), 64'(v.exp_op_ready));
    checkOutput({tag, " vrf_valid"}, 64'(vrf_req_valid), 64'(v.exp_vrf_valid));
    checkOutput({tag, " opq_valid"}, 64'(opq_valid), 64'(v.exp_opq_valid));
    if (v.exp_vrf_valid || v.rst) begin
      checkOutput({tag, " raddr"}, 64'(vrf_raddr), 64'(v.exp_addr));
    end
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i         = 1'b1;
    op_req_valid  = 1'b0;
    vrf_req_ready = 1'b1;
    opq_ready     = 3'b000;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic sendReq(input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [2:0] qreq, input logic [15:0] vlb);
    @(negedge clk_i);
    op_req.vs1       = vs1;
    op_req.vs2       = vs2;
    op_req.queue_req = qreq;
    op_req.vlB       = vlb;
    op_req_valid     = 1'b1;
    #1;
    checkOutput("req accept ready", 64'(op_req_ready), 64'd1);
    @(negedge clk_i);
    op_req_valid = 1'b0;
  endtask

  task automatic popCheck(input int q, input logic [7:0] addr, input string tag);
    @(negedge clk_i);
    opq_ready    = 3'b000;
    opq_ready[q] = 1'b1;
    #1;
    checkOutput({tag, " valid"}, 64'(opq_valid[q]), 64'd1);
    checkOutput({tag, " data"}, opq_data[q], mkData(addr));
  endtask

  task automatic collectWords(input int q, input logic [7:0] base, input int nwords,
                              input bit rand_ready, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < nwords && cyc < budget) begin
      @(negedge clk_i);
      if (rand_ready) vrf_req_ready = ($urandom_range(0, 1) != 0);
      opq_ready    = 3'b000;
      opq_ready[q] = 1'b1;
      #1;
      if (opq_valid[q]) begin
        checkOutput($sformatf("q%0d word%0d", q, got), opq_data[q],
                    mkData(vrf_addr_t'(int'(base) + got)));
        got++;
      end
      cyc++;
    end
    if (got < nwords) begin
      checks++;
      failures++;
      $display("[TB] FAIL q%0d collect: got %0d words expected %0d", q, got, nwords);
    end
    @(negedge clk_i);
    opq_ready     = 3'b000;
    vrf_req_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    rst_i         = 1'b1;
    op_req        = '0;
    op_req_valid  = 1'b0;
    vrf_req_ready = 1'b1;
    opq_ready     = 3'b000;

    // Single queue (ALUA, vs1=2 -> addr 16), then zero-length and empty requests.
    vecs_a.push_back('{1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b000});
    vecs_a.push_back('{1'b0, 1'b1, 5'd2, 5'd0, 3'b001, 16'd64, 1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b000});
    vecs_a.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b0, 1'b1, 8'd16, 3'b000});
    vecs_a.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b0, 1'b1, 8'd17, 3'b000});
    vecs_a.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b0, 1'b1, 8'd18, 3'b001});
    vecs_a.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b0, 1'b1, 8'd19, 3'b001});
    vecs_a.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b001});
    vecs_a.push_back('{1'b0, 1'b1, 5'd7, 5'd0, 3'b001, 16'd0,  1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b001});
    vecs_a.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b001});
    vecs_a.push_back('{1'b0, 1'b1, 5'd7, 5'd0, 3'b000, 16'd64, 1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b001});
    vecs_a.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b001});

    // Two queues round-robin: ALUA vs1=1 (addr 8), ALUB vs2=5 (addr 40), 2 words each.
    vecs_b.push_back('{1'b1, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b000});
    vecs_b.push_back('{1'b0, 1'b1, 5'd1, 5'd5, 3'b011, 16'd32, 1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b000});
    vecs_b.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b0, 1'b1, 8'd8,  3'b000});
    vecs_b.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b0, 1'b1, 8'd40, 3'b000});
    vecs_b.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b0, 1'b1, 8'd9,  3'b001});
    vecs_b.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b0, 1'b1, 8'd41, 3'b011});
    vecs_b.push_back('{1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 16'd0,  1'b1, 3'b000, 1'b1, 1'b0, 8'd0,  3'b011});

    repeat (2) @(negedge clk_i);

    hs_base = hs_count;
    foreach (vecs_a[i]) applyStimulus(vecs_a[i], $sformatf("A%0d", i));
`ifdef OPERAND_REQUESTER_STALL_CNT_EN
    checkOutput("A stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    checkOutput("A read count", 64'(hs_count - hs_base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      popCheck(0, 8'(16 + i), $sformatf("A pop%0d", i));
      checkOutput($sformatf("A pop%0d others", i), 64'(opq_valid[2:1]), 64'd0);
    end
    @(negedge clk_i);
    opq_ready = 3'b000;
    #1;
    checkOutput("A drained", 64'(opq_valid), 64'd0);

    hs_base = hs_count;
    foreach (vecs_b[i]) applyStimulus(vecs_b[i], $sformatf("B%0d", i));
    checkOutput("B read count", 64'(hs_count - hs_base), 64'd4);
    popCheck(0, 8'd8,  "B alua0");
    popCheck(0, 8'd9,  "B alua1");
    popCheck(1, 8'd40, "B alub0");
    popCheck(1, 8'd41, "B alub1");
    @(negedge clk_i);
    opq_ready = 3'b000;
    #1;
    checkOutput("B drained", 64'(opq_valid), 64'd0);

    // Credit backpressure: 8-word ALUA request with the queue never popped.
    doReset();
    hs_base = hs_count;
    sendReq(5'd3, 5'd0, 3'b001, 16'd128);
    repeat (12) @(negedge clk_i);
    #1;
    checkOutput("BP reads held", 64'(hs_count - hs_base), 64'd4);
    checkOutput("BP vrf_valid low", 64'(vrf_req_valid), 64'd0);
    checkOutput("BP busy", 64'(op_req_ready), 64'd0);
    collectWords(0, 8'd24, 8, 1'b0, 60);
    #1;
    checkOutput("BP total reads", 64'(hs_count - hs_base), 64'd8);
    checkOutput("BP idle", 64'(op_req_ready), 64'd1);
    checkOutput("BP drained", 64'(opq_valid), 64'd0);

    // Random port stalls: 6-word ALUB request (vs2=4 -> addr 32).
    doReset();
    hs_base      = hs_count;
    exp_stall    = 0;
    track_hs     = 0;
    track_target = 6;
    sendReq(5'd0, 5'd4, 3'b010, 16'd96);
    track_busy = 1;
    collectWords(1, 8'd32, 6, 1'b1, 300);
    #1;
    checkOutput("ST total reads", 64'(hs_count - hs_base), 64'd6);
    checkOutput("ST tracking done", 64'(track_busy), 64'd0);
    checkOutput("ST drained", 64'(opq_valid), 64'd0);
`ifdef OPERAND_REQUESTER_STALL_CNT_EN
    checkOutput("ST stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif

    // Reset after two of eight reads: everything clears, no late push.
    doReset();
    hs_base = hs_count;
    sendReq(5'd3, 5'd0, 3'b001, 16'd128);
    cyc = 0;
    while ((hs_count - hs_base) < 2 && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    #1;
    checkOutput("RST two reads", 64'(hs_count - hs_base), 64'd2);
    checkOutput("RST pre valid", 64'(opq_valid), 64'b001);
    rst_i = 1'b1;
    #1;
    checkOutput("RST opq_valid", 64'(opq_valid), 64'd0);
    checkOutput("RST op_ready", 64'(op_req_ready), 64'd1);
    checkOutput("RST vrf_valid", 64'(vrf_req_valid), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      checkOutput($sformatf("RST post%0d opq_valid", i), 64'(opq_valid), 64'd0);
      checkOutput($sformatf("RST post%0d vrf_valid", i), 64'(vrf_req_valid), 64'd0);
    end
    checkOutput("RST no more reads", 64'(hs_count - hs_base), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
